wb_to_i2s_tx: RTL



---
 rtl/wb_to_i2s_tx_if.sv | 19 +
 rtl/wb_to_i2s_tx.sv | 128 ++++++++++++
 2 files changed

// File: rtl/wb_to_i2s_tx_if.sv
// wb_to_i2s_tx_if: Wishbone classic slave bus bundle for the I2S transmitter.
interface wb_to_i2s_tx_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );
    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_to_i2s_tx.sv
// wb_to_i2s_tx: Wishbone-fed frame FIFO driving an I2S master transmitter (sck/ws/sd).
// Define WB_TO_I2S_IRQ_EN to enable the FIFO-low/underflow interrupt and CTRL.IRQ_EN.
module wb_to_i2s_tx #(
    parameter int         FIFO_AW    = 3,
    parameter logic [7:0] CLKDIV_RST = 8'h03
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    wb_to_i2s_tx_if.slave wb,
    output logic          i2s_sck_o,
    output logic          i2s_ws_o,
    output logic          i2s_sd_o,
    output logic          irq_o
);
    localparam int DEPTH = 1 << FIFO_AW;
    logic [1:0]         ctrl;
    logic [7:0]         clkdiv;
    logic [7:0]         div_cnt;
    logic [7:0]         div_lim;
    logic [FIFO_AW:0]   level;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [31:0]        mem [DEPTH];
    logic [4:0]         bit_cnt;
    logic [31:0]        shift_reg;
    logic               underflow;
    logic               overflow;
    logic [2:0]         reg_sel;
    logic               req;
    logic               wr_en;
    logic               full;
    logic               empty;
    logic               fall;
    logic               pop_req;
    logic               pop;
    logic               push_req;
    logic               push;
    logic               clr_uf;
    logic               clr_of;
    logic [4:0]         bit_nxt;
    logic [31:0]        shift_nxt;
    logic [31:0]        status;
    logic [31:0]        rdata;
    logic               unused_ok;
    assign unused_ok = ^{wb.wb_sel_i, wb.wb_adr_i[31:5], wb.wb_adr_i[1:0]};
    always_comb begin
        reg_sel   = wb.wb_adr_i[4:2];
        req       = wb.wb_cyc_i & wb.wb_stb_i;
        wr_en     = wb.wb_ack_o & req & wb.wb_we_i;
        full      = level == (FIFO_AW+1)'(DEPTH);
        empty     = level == '0;
        fall      = ctrl[0] & i2s_sck_o & (div_cnt == div_lim);
        bit_nxt   = bit_cnt + 5'd1;
        pop_req   = fall & (bit_nxt == 5'd0);
        pop       = pop_req & ~empty;
        push_req  = wr_en & (reg_sel == 3'd1);
        // a pop in the same cycle frees a slot, so a push to a full FIFO still lands
        push      = push_req & (~full | pop);
        clr_uf    = wr_en & (reg_sel == 3'd2) & wb.wb_dat_i[18];
        clr_of    = wr_en & (reg_sel == 3'd2) & wb.wb_dat_i[19];
        shift_nxt = pop_req ? (pop ? mem[rd_ptr] : '0) : {shift_reg[30:0], 1'b0};
        status    = {12'd0, overflow, underflow, empty, full, 16'(level)};
        rdata     = (reg_sel == 3'd0) ? {30'd0, ctrl} :
                    (reg_sel == 3'd2) ? status :
                    (reg_sel == 3'd4) ? {24'd0, clkdiv} : '0;
    end
    always_ff @(posedge wb_clk_i)
        if (push) mem[wr_ptr] <= wb.wb_dat_i;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_dat_o <= '0;
            ctrl        <= '0;
            clkdiv      <= CLKDIV_RST;
            div_cnt     <= '0;
            div_lim     <= CLKDIV_RST;
            level       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            bit_cnt     <= 5'd31;
            shift_reg   <= '0;
            underflow   <= 1'b0;
            overflow    <= 1'b0;
            i2s_sck_o   <= 1'b0;
            i2s_ws_o    <= 1'b0;
            i2s_sd_o    <= 1'b0;
            irq_o       <= 1'b0;
        end else begin
            wb.wb_ack_o <= req & ~wb.wb_ack_o;
            if (req & ~wb.wb_ack_o) wb.wb_dat_o <= rdata;
`ifdef WB_TO_I2S_IRQ_EN
            if (wr_en && reg_sel == 3'd0) ctrl <= wb.wb_dat_i[1:0];
            irq_o <= ctrl[1] & ((level <= (FIFO_AW+1)'(DEPTH / 2)) | underflow);
`else
            if (wr_en && reg_sel == 3'd0) ctrl <= {1'b0, wb.wb_dat_i[0]};
            irq_o <= 1'b0;
`endif
            if (wr_en && reg_sel == 3'd4) clkdiv <= wb.wb_dat_i[7:0];
            underflow <= (pop_req & empty) | (underflow & ~clr_uf);
            overflow  <= (push_req & ~push) | (overflow & ~clr_of);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
            // divider limit is latched at each wrap so CLKDIV changes never cut a half-period short
            if (!ctrl[0]) begin
                i2s_sck_o <= 1'b0;
                i2s_ws_o  <= 1'b0;
                i2s_sd_o  <= 1'b0;
                div_cnt   <= '0;
                div_lim   <= clkdiv;
                bit_cnt   <= 5'd31;
                shift_reg <= '0;
            end else if (div_cnt == div_lim) begin
                div_cnt   <= '0;
                div_lim   <= clkdiv;
                i2s_sck_o <= ~i2s_sck_o;
                if (i2s_sck_o) begin
                    bit_cnt   <= bit_nxt;
                    shift_reg <= shift_nxt;
                    i2s_sd_o  <= shift_nxt[31];
                    i2s_ws_o  <= (bit_nxt >= 5'd15) && (bit_nxt <= 5'd30);
                end
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end
endmodule
